alu_mul_ctrl: RTL
=================

ALU_MUL_CTRL -- requirements
Module: alu_mul_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the operand width N.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  request to multiply a by b; sampled only in IDLE.
REQ-006 Port a  input  N  multiplicand, unsigned.
REQ-007 Port b  input  N  multiplier, unsigned.
REQ-008 Port busy  output  1  high in every state except IDLE.
REQ-009 Port done  output  1  one-cycle pulse, high only in state DONE.
REQ-010 Port product  output  2N  unsigned a*b; valid from done until the next accepted start.
REQ-011 Port alu_a  output  N  ALU operand A; equals the P_hi register.
REQ-012 Port alu_b  output  N  ALU operand B; equals the M register.
REQ-013 Port alu_opcode  output  5  ALU opcode: 5'h02 (ADD) in state ADD, 5'h00 (LD) in all other states.
REQ-014 Port alu_c  input  N  ALU result C, combinational from alu_a, alu_b and alu_opcode.

Function
REQ-015 Registers: M (N bits), Q (N bits), P_hi (N bits), cy (1 bit), cnt (log2 N bits), state.
REQ-016 States SHALL be IDLE, ADD, SHIFT and DONE.
REQ-017 IDLE with start=1: latch M<=a, Q<=b, P_hi<=0, cy<=0, cnt<=0; go to ADD if b[0]=1, else SHIFT.
REQ-018 IDLE with start=0: hold all registers, including product.
REQ-019 ADD: P_hi<=alu_c; cy<=(alu_c < P_hi), an unsigned compare that recovers the carry; next state SHIFT.
REQ-020 The block SHALL NOT use the ALU status flags; carry comes only from REQ-019.
REQ-021 SHIFT: {cy,P_hi,Q} SHALL shift right by 1 with 0 into the MSB, so cy becomes 0; cnt<=cnt+1.
REQ-022 SHIFT with cnt=N-1: next state DONE; otherwise next state ADD if the post-shift Q[0] (old Q[1]) is 1, else SHIFT.
REQ-023 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-024 product SHALL equal {P_hi,Q} at all times.
REQ-025 product SHALL be held unchanged from DONE until the next accepted start.
REQ-026 Latency: with start accepted at edge E0 and k = popcount(b), done SHALL be high in the cycle after edge E0+N+k.
REQ-027 Latency range for N=8 SHALL be 8..16 cycles.
REQ-028 start SHALL be ignored while busy=1; no queuing, and operands are not relatched.
REQ-029 start may be held high: a new operation SHALL be accepted on the first IDLE cycle after DONE.
REQ-030 a and b SHALL be don't-care except on the accepting edge.
REQ-031 The ALU SHALL be driven only in state ADD; in all other states alu_c is ignored.
REQ-032 All register updates SHALL occur on the rising edge of clk; outputs SHALL be decoded from registers only, with no combinational path from start to any output.

Reset
REQ-033 While reset=1: state=IDLE, busy=0, done=0, M=0, Q=0, P_hi=0, cy=0, cnt=0, product=0, alu_opcode=5'h00, alu_a=0, alu_b=0.
REQ-034 Reset asserted mid-operation SHALL abort immediately with no done pulse.
REQ-035 The first start after reset deasserts SHALL be accepted normally.

Verification
REQ-036 N=8, a=13, b=11, start for 1 cycle -> busy for 11 cycles, then done pulse with product=16'h008F, then IDLE.
REQ-037 a=255, b=255 -> 8 ADD cycles, each with alu_opcode=5'h02 and carry recovered; done at E0+16 with product=16'hFE01.
REQ-038 a=200, b=0 -> no ADD states and alu_opcode stays 5'h00; done at E0+8 with product=0.
REQ-039 Start a=3, b=5; pulse start again with a=7, b=7 during busy -> product=16'h000F, single done pulse, second request ignored.
REQ-040 Assert reset during SHIFT of a=255, b=255 -> next cycle busy=0, done=0, product=0; a new start a=2, b=3 then gives product=16'h0006.
REQ-041 Hold start=1 continuously with a=1, b=1 -> back-to-back operations, each done pulse 9 cycles after acceptance, product=16'h0001.

Source files
------------

// File: rtl/alu_mul_ctrl.sv
// Sequential shift-add unsigned multiplier that borrows an external ALU for its additions.
// Latency: done pulses N+popcount(b) cycles after the accepting edge (8..16 cycles for N=8).
// Backpressure: start is only looked at in IDLE; requests while busy are dropped, not queued.
module alu_mul_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic                    busy,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] product,
    output logic [DATA_WIDTH-1:0]   alu_a,
    output logic [DATA_WIDTH-1:0]   alu_b,
    output logic [4:0]              alu_opcode,
    input  logic [DATA_WIDTH-1:0]   alu_c
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [4:0] OP_LD  = 5'h00;
    localparam logic [4:0] OP_ADD = 5'h02;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] m_reg;
    logic [DATA_WIDTH-1:0] q_reg;
    logic [DATA_WIDTH-1:0] p_hi;
    logic                  cy;
    logic [CW-1:0]         cnt;

    // State register; reset drops straight back to IDLE, aborting any operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one optional ADD per multiplier bit, always followed by a SHIFT.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = b[0] ? ADD : SHIFT;
                end
            end
            ADD: begin
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end else begin
                    // q_reg[1] is the bit that lands in Q[0] after this shift.
                    state_nxt = q_reg[1] ? ADD : SHIFT;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: latch operands, accumulate through the ALU, shift {cy,P_hi,Q} right.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_reg <= '0;
            q_reg <= '0;
            p_hi  <= '0;
            cy    <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= a;
                        q_reg <= b;
                        p_hi  <= '0;
                        cy    <= 1'b0;
                        cnt   <= '0;
                    end
                end
                ADD: begin
                    p_hi <= alu_c;
                    // The ALU wraps modulo 2^N, so a smaller result means a carry out.
                    cy   <= (alu_c < p_hi);
                end
                SHIFT: begin
                    {cy, p_hi, q_reg} <= {1'b0, cy, p_hi, q_reg[DATA_WIDTH-1:1]};
                    cnt               <= cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode from the state register only, so start never reaches them combinationally.
    always_comb begin
        busy       = (state != IDLE);
        done       = (state == DONE);
        alu_opcode = (state == ADD) ? OP_ADD : OP_LD;
    end

    assign product = {p_hi, q_reg};
    assign alu_a   = p_hi;
    assign alu_b   = m_reg;

endmodule
